la_capture_engine: RTL and testbench

- Parametrised trigger-capture engine for the tiny logic analyzer; successor to the single-shot trigger-capture mode.
- Samples CH input channels at a programmable rate into a DEPTH-entry circular buffer.
- Retains a programmable number of pre-trigger samples and supports masked level or edge triggering.
- After capture, the buffer is read out oldest-first through a request/valid port; it sits between the ui_in channel pins and the uo_out output mux.

---
 rtl/la_capture_engine.sv | 140 ++++++++++++++
 tb/tb_la_capture_engine.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/la_capture_engine.sv
// Trigger-capture engine: samples CH channels into a DEPTH-entry ring, keeping pretrig samples ahead of the trigger.
// Readout latency is 1 clock; rd_req is dropped outside DONE or after DEPTH reads (no backpressure).
module la_capture_engine #(
  parameter int CH    = 4,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    sample_in,
  input  logic             arm,
  input  logic [CH-1:0]    trig_mask,
  input  logic [CH-1:0]    trig_value,
  input  logic             trig_edge,
  input  logic [AW-1:0]    pretrig,
  input  logic [DIV_W-1:0] rate_div,
  input  logic             rd_req,
  output logic [CH-1:0]    rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             triggered,
  output logic             done
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t           state, state_nxt;
  logic             arm_q;
  logic [CH-1:0]    mask_q, value_q;
  logic             edge_q;
  logic [AW-1:0]    pretrig_q;
  logic [DIV_W-1:0] div_q, div_cnt;
  logic [AW-1:0]    wr_ptr, rd_ptr, trig_addr;
  logic [AW:0]      post_cnt, rd_cnt, post_need;
  logic             prev_match;
  logic [CH-1:0]    mem [DEPTH];

  logic             arm_rise, strobe, match, fire, wr_en, cap_active;
  logic [AW-1:0]    wr_ptr_inc, trig_sel;

  assign arm_rise   = arm & ~arm_q;
  assign strobe     = (div_cnt == '0);
  assign match      = (((sample_in ^ value_q) & mask_q) == '0);
  assign post_need  = DEPTH_L - {1'b0, pretrig_q};
  assign wr_ptr_inc = wr_ptr + AW'(1);
  assign cap_active = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign busy       = cap_active;
  assign done       = (state == S_DONE);
  // When WAIT goes straight to DONE the trigger address is not registered yet.
  assign trig_sel   = fire ? wr_ptr : trig_addr;

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    wr_en     = 1'b0;
    if (arm_rise) begin
      state_nxt = (pretrig == '0) ? S_WAIT : S_PRE;
    end else begin
      case (state)
        S_PRE: if (strobe) begin
          wr_en = 1'b1;
          if (wr_ptr_inc == pretrig_q) state_nxt = S_WAIT;
        end
        S_WAIT: if (strobe) begin
          wr_en = 1'b1;
          fire  = (mask_q == '0) || (edge_q ? (match && !prev_match) : match);
          if (fire) state_nxt = (post_need == (AW+1)'(1)) ? S_DONE : S_POST;
        end
        S_POST: if (strobe) begin
          wr_en = 1'b1;
          if (post_cnt + (AW+1)'(1) == post_need) state_nxt = S_DONE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      arm_q      <= 1'b0;
      mask_q     <= '0;
      value_q    <= '0;
      edge_q     <= 1'b0;
      pretrig_q  <= '0;
      div_q      <= '0;
      div_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      trig_addr  <= '0;
      post_cnt   <= '0;
      rd_cnt     <= '0;
      prev_match <= 1'b0;
      triggered  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      arm_q    <= arm;
      state    <= state_nxt;
      rd_valid <= 1'b0;
      if (arm_rise) begin
        mask_q     <= trig_mask;
        value_q    <= trig_value;
        edge_q     <= trig_edge;
        pretrig_q  <= pretrig;
        div_q      <= rate_div;
        div_cnt    <= '0;
        wr_ptr     <= '0;
        rd_cnt     <= '0;
        post_cnt   <= '0;
        prev_match <= 1'b1;
        triggered  <= 1'b0;
      end else begin
        if (cap_active) div_cnt <= strobe ? div_q : div_cnt - DIV_W'(1);
        if (wr_en) wr_ptr <= wr_ptr_inc;
        if (state == S_WAIT && strobe) prev_match <= match;
        if (fire) begin
          trig_addr <= wr_ptr;
          post_cnt  <= (AW+1)'(1);
          triggered <= 1'b1;
        end
        if (state == S_POST && strobe) post_cnt <= post_cnt + (AW+1)'(1);
        // Oldest retained sample sits pretrig entries behind the trigger.
        if (state_nxt == S_DONE && state != S_DONE) rd_ptr <= trig_sel - pretrig_q;
        if (state == S_DONE && rd_req && rd_cnt != DEPTH_L) begin
          rd_data  <= mem[rd_ptr];
          rd_valid <= 1'b1;
          rd_ptr   <= rd_ptr + AW'(1);
          rd_cnt   <= rd_cnt + (AW+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_in;
  end

endmodule

// File: tb/tb_la_capture_engine.sv
// Directed bench for la_capture_engine: table of ramp captures plus hand sequences for edge, busy-read, re-arm and reset.
module tb_la_capture_engine;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sample_in, trig_mask, trig_value, pretrig, rd_data;
  logic [7:0] rate_div;
  logic       arm, trig_edge, rd_req, rd_valid, busy, triggered, done;

  int n_tests = 0;
  int n_fail  = 0;

  la_capture_engine #(.CH(4), .DEPTH(16), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .arm(arm),
    .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
    .pretrig(pretrig), .rate_div(rate_div), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pre;
    logic [7:0]  div;
    logic [3:0]  mask;
    logic [3:0]  value;
    logic        edg;
    logic [3:0]  start;
    logic [3:0]  exp_trig;
    int          exp_done;
    logic [63:0] exp_reads;
  } row_t;

  row_t rows[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arms with the row's config, ramps sample_in every clock, then reads out 16+1 entries.
  task automatic run_row(input row_t r, input int idx);
    int   cyc, done_cyc, trig_cyc;
    logic [3:0] trig_smp;
    bit   seen_trig;
    arm = 1'b0;
    tick();
    trig_mask = r.mask; trig_value = r.value; trig_edge = r.edg;
    pretrig = r.pre; rate_div = r.div;
    sample_in = r.start; arm = 1'b1;
    cyc = 0; done_cyc = -1; trig_cyc = -1; seen_trig = 0; trig_smp = '0;
    tick(); cyc++;
    check($sformatf("row%0d_arm_state", idx), {busy, triggered, done}, 3'b100);
    sample_in = sample_in + 4'd1;
    for (int k = 0; k < 300 && done_cyc < 0; k++) begin
      tick(); cyc++;
      if (triggered && !seen_trig) begin
        seen_trig = 1; trig_smp = sample_in; trig_cyc = cyc;
      end
      if (done) done_cyc = cyc;
      sample_in = sample_in + 4'd1;
    end
    check($sformatf("row%0d_trig_sample", idx), {seen_trig, trig_smp}, {1'b1, r.exp_trig});
    check($sformatf("row%0d_done_cycle", idx), done_cyc, r.exp_done);
    if (r.pre == 4'd15)
      check($sformatf("row%0d_done_with_trig", idx), done_cyc, trig_cyc);
    rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("row%0d_read%0d", idx, i), {rd_valid, rd_data},
            {1'b1, r.exp_reads[63-4*i -: 4]});
    end
    tick();
    check($sformatf("row%0d_read17", idx), {rd_valid, rd_data}, {1'b0, r.exp_reads[3:0]});
    rd_req = 1'b0;
  endtask

  initial begin
    bit any_trig;
    rows[0] = '{4'd4,  8'd0, 4'hF, 4'hA, 1'b0, 4'h0, 4'hA, 22, 64'h6789ABCDEF012345};
    rows[1] = '{4'd0,  8'd3, 4'h0, 4'h5, 1'b1, 4'hF, 4'h0, 62, 64'h048C048C048C048C};
    rows[2] = '{4'd15, 8'd0, 4'hF, 4'hA, 1'b0, 4'h0, 4'hA, 27, 64'hBCDEF0123456789A};
    rows[3] = '{4'd0,  8'd0, 4'h3, 4'h2, 1'b0, 4'h0, 4'h2, 18, 64'h23456789ABCDEF01};
    rows[4] = '{4'd2,  8'd0, 4'h1, 4'h1, 1'b1, 4'h0, 4'h5, 19, 64'h3456789ABCDEF012};
    rows[5] = '{4'd2,  8'd0, 4'h1, 4'h1, 1'b0, 4'h0, 4'h3, 17, 64'h123456789ABCDEF0};
    rows[6] = '{4'd1,  8'd1, 4'hF, 4'h9, 1'b0, 4'h0, 4'h9, 38, 64'h79BDF13579BDF135};

    rst_n = 1'b0; arm = 1'b0; rd_req = 1'b0; sample_in = '0;
    trig_mask = '0; trig_value = '0; trig_edge = 1'b0; pretrig = '0; rate_div = '0;
    repeat (3) tick();
    check("reset_outputs", {rd_data, rd_valid, busy, triggered, done}, '0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    rd_req = 1'b1;
    tick();
    check("idle_read_ignored", {rd_valid, done}, 2'b00);
    rd_req = 1'b0;

    for (int i = 0; i < 7; i++) run_row(rows[i], i);

    // Edge trigger with the condition already true at arm.
    arm = 1'b0; tick();
    trig_mask = 4'hF; trig_value = 4'hA; trig_edge = 1'b1; pretrig = 4'd1; rate_div = '0;
    sample_in = 4'hA; arm = 1'b1;
    any_trig = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (triggered) any_trig = 1;
    end
    check("edge_held_no_fire", any_trig, 1'b0);
    sample_in = 4'h3; tick();
    check("edge_after_3", triggered, 1'b0);
    sample_in = 4'hA; tick();
    check("edge_second_A", triggered, 1'b1);
    for (int k = 0; k < 100 && !done; k++) tick();
    check("edge_done", done, 1'b1);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    check("edge_read0", {rd_valid, rd_data}, {1'b1, 4'h3});
    tick();
    check("edge_gap", rd_valid, 1'b0);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    check("edge_read1", {rd_valid, rd_data}, {1'b1, 4'hA});

    // Read while busy, then re-arm from WAIT.
    arm = 1'b0; tick();
    trig_mask = 4'hF; trig_value = 4'h5; trig_edge = 1'b0; pretrig = 4'd0;
    sample_in = 4'h0; arm = 1'b1;
    repeat (4) tick();
    rd_req = 1'b1; tick();
    check("busy_read_ignored", {rd_valid, busy, triggered, done}, 4'b0100);
    rd_req = 1'b0;
    run_row(rows[0], 10);

    // Asynchronous reset during POST.
    arm = 1'b0; tick();
    trig_mask = 4'h0; trig_edge = 1'b0; pretrig = 4'd0; rate_div = 8'd3; arm = 1'b1;
    repeat (10) tick();
    check("post_state", {busy, triggered, done}, 3'b110);
    arm = 1'b0;
    #3 rst_n = 1'b0;
    #1 check("async_reset", {rd_data, rd_valid, busy, triggered, done}, '0);
    @(negedge clk) rst_n = 1'b1;
    run_row(rows[3], 11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
